// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state encoding and forwarding select codes for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// pipe_ctrl_fwd_sel: forwarding source select for one EX operand, EX/MEM beats MEM/WB
module pipe_ctrl_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_W     = 4,
    parameter int FWD_EN        = 1,
    parameter int ZERO_REG_HARD = 1
) (
    input  logic [REGADDR_W-1:0] src_i,
    input  logic [REGADDR_W-1:0] mem_rd_i,
    input  logic                 mem_reg_write_i,
    input  logic [REGADDR_W-1:0] wb_rd_i,
    input  logic                 wb_reg_write_i,
    output logic [1:0]           sel_o
);
    logic mem_hit, wb_hit;

    assign mem_hit = mem_reg_write_i && mem_rd_i == src_i && !(ZERO_REG_HARD != 0 && mem_rd_i == '0);
    assign wb_hit  = wb_reg_write_i && wb_rd_i == src_i && !(ZERO_REG_HARD != 0 && wb_rd_i == '0);
    assign sel_o   = (FWD_EN == 0) ? FWD_IDEX : mem_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_IDEX;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/forward/jump/halt control for the 5-stage CPU with DMEM wait,
// halt-drain FSM and saturating performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_W     = 4,
    parameter int CNT_W         = 32,
    parameter int DRAIN_DEPTH   = 3,
    parameter int FWD_EN        = 1,
    parameter int ZERO_REG_HARD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REGADDR_W-1:0] id_rs_i,
    input  logic [REGADDR_W-1:0] id_rt_i,
    input  logic                 id_uses_rs_i,
    input  logic                 id_uses_rt_i,
    input  logic                 id_jump_i,
    input  logic                 id_halt_i,
    input  logic [REGADDR_W-1:0] ex_rs_i,
    input  logic [REGADDR_W-1:0] ex_rt_i,
    input  logic [REGADDR_W-1:0] ex_rd_i,
    input  logic                 ex_reg_write_i,
    input  logic                 ex_mem_read_i,
    input  logic [REGADDR_W-1:0] mem_rd_i,
    input  logic                 mem_reg_write_i,
    input  logic [REGADDR_W-1:0] wb_rd_i,
    input  logic                 wb_reg_write_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    input  logic                 retire_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 pipe_hold_o,
    output logic [1:0]           forward_a_o,
    output logic [1:0]           forward_b_o,
    output logic                 halted_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     retire_cnt_o
);
    localparam int DW = (DRAIN_DEPTH < 2) ? 1 : $clog2(DRAIN_DEPTH + 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             halted_q;
    logic [CNT_W-1:0] cyc_q, stl_q, ret_q;
    logic [1:0]       sel_a, sel_b;
    logic             hold, raw, raw_rs, raw_rt, halt_go;

    function automatic logic hit(input logic we, input logic [REGADDR_W-1:0] rd, input logic [REGADDR_W-1:0] src);
        return we && rd == src && !(ZERO_REG_HARD != 0 && rd == '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    pipe_ctrl_fwd_sel #(.REGADDR_W(REGADDR_W), .FWD_EN(FWD_EN), .ZERO_REG_HARD(ZERO_REG_HARD)) u_fwd_a (
        .src_i(ex_rs_i), .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .sel_o(sel_a)
    );

    pipe_ctrl_fwd_sel #(.REGADDR_W(REGADDR_W), .FWD_EN(FWD_EN), .ZERO_REG_HARD(ZERO_REG_HARD)) u_fwd_b (
        .src_i(ex_rt_i), .mem_rd_i(mem_rd_i), .mem_reg_write_i(mem_reg_write_i),
        .wb_rd_i(wb_rd_i), .wb_reg_write_i(wb_reg_write_i), .sel_o(sel_b)
    );

    // without forwarding every in-flight writer of an ID source must be waited out
    assign raw_rs = id_uses_rs_i && (hit(ex_mem_read_i, ex_rd_i, id_rs_i) || (FWD_EN == 0 &&
                    (hit(ex_reg_write_i, ex_rd_i, id_rs_i) || hit(mem_reg_write_i, mem_rd_i, id_rs_i) ||
                     hit(wb_reg_write_i, wb_rd_i, id_rs_i))));
    assign raw_rt = id_uses_rt_i && (hit(ex_mem_read_i, ex_rd_i, id_rt_i) || (FWD_EN == 0 &&
                    (hit(ex_reg_write_i, ex_rd_i, id_rt_i) || hit(mem_reg_write_i, mem_rd_i, id_rt_i) ||
                     hit(wb_reg_write_i, wb_rd_i, id_rt_i))));
    assign raw     = raw_rs || raw_rt;
    assign hold    = dmem_req_i && !dmem_ready_i;
    assign halt_go = id_halt_i && state_q == RUN && !hold && !raw && !id_jump_i;

    assign forward_a_o  = reset ? FWD_IDEX : sel_a;
    assign forward_b_o  = reset ? FWD_IDEX : sel_b;
    assign halted_o     = halted_q;
    assign cycle_cnt_o  = cyc_q;
    assign stall_cnt_o  = stl_q;
    assign retire_cnt_o = ret_q;

    always_comb begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (reset) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (hold) begin
            pipe_hold_o = 1'b1;
        end else if (state_q != RUN || raw) begin
            id_ex_flush_o = 1'b1;
        end else if (id_jump_i) begin
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (id_halt_i) begin
            id_ex_flush_o = 1'b1;
        end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (halt_go) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_DEPTH);
        end else if (state_q == DRAIN && !hold) begin
            drain_d = drain_q - DW'(1);
            state_d = (drain_q <= DW'(1)) ? HALTED : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
            cyc_q    <= '0;
            stl_q    <= '0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= state_d == HALTED;
            cyc_q    <= sat_inc(cyc_q, state_q != HALTED);
            stl_q    <= sat_inc(stl_q, hold || raw);
            ret_q    <= sat_inc(ret_q, retire_i);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench; u0 uses defaults, u1 has FWD_EN=0 and 4-bit counters
module tb_pipe_ctrl;
    typedef struct packed {
        logic       reset;
        logic [3:0] id_rs, id_rt;
        logic       uses_rs, uses_rt, jump, halt;
        logic [3:0] ex_rs, ex_rt, ex_rd;
        logic       ex_rw, ex_mr;
        logic [3:0] mem_rd;
        logic       mem_rw;
        logic [3:0] wb_rd;
        logic       wb_rw, req, rdy, retire;
    } in_t;

    typedef struct packed {
        int          tag;
        logic        d;
        logic [4:0]  ctrl;
        logic [1:0]  fa, fb;
        logic        chk, halted;
        logic [31:0] cyc, stl, ret;
    } exp_t;

    // ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
    localparam logic [4:0] C_RUN = 5'b11000, C_RST = 5'b00110, C_HOLD = 5'b00001;
    localparam logic [4:0] C_BUB = 5'b00010, C_JMP = 5'b10110;

    logic clk = 1'b0;
    in_t  i0, i1;
    exp_t q[$];
    int   n_tests = 0, n_fail = 0;

    logic [4:0]  ctrl0, ctrl1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic        h0, h1;
    logic [31:0] cyc0, stl0, ret0;
    logic [3:0]  cyc1, stl1, ret1;

    always #5 clk = ~clk;

    pipe_ctrl u0 (
        .clk(clk), .reset(i0.reset), .id_rs_i(i0.id_rs), .id_rt_i(i0.id_rt),
        .id_uses_rs_i(i0.uses_rs), .id_uses_rt_i(i0.uses_rt), .id_jump_i(i0.jump), .id_halt_i(i0.halt),
        .ex_rs_i(i0.ex_rs), .ex_rt_i(i0.ex_rt), .ex_rd_i(i0.ex_rd), .ex_reg_write_i(i0.ex_rw),
        .ex_mem_read_i(i0.ex_mr), .mem_rd_i(i0.mem_rd), .mem_reg_write_i(i0.mem_rw),
        .wb_rd_i(i0.wb_rd), .wb_reg_write_i(i0.wb_rw), .dmem_req_i(i0.req), .dmem_ready_i(i0.rdy),
        .retire_i(i0.retire), .pc_write_o(ctrl0[4]), .if_id_write_o(ctrl0[3]), .if_id_flush_o(ctrl0[2]),
        .id_ex_flush_o(ctrl0[1]), .pipe_hold_o(ctrl0[0]), .forward_a_o(fa0), .forward_b_o(fb0),
        .halted_o(h0), .cycle_cnt_o(cyc0), .stall_cnt_o(stl0), .retire_cnt_o(ret0)
    );

    pipe_ctrl #(.CNT_W(4), .FWD_EN(0)) u1 (
        .clk(clk), .reset(i1.reset), .id_rs_i(i1.id_rs), .id_rt_i(i1.id_rt),
        .id_uses_rs_i(i1.uses_rs), .id_uses_rt_i(i1.uses_rt), .id_jump_i(i1.jump), .id_halt_i(i1.halt),
        .ex_rs_i(i1.ex_rs), .ex_rt_i(i1.ex_rt), .ex_rd_i(i1.ex_rd), .ex_reg_write_i(i1.ex_rw),
        .ex_mem_read_i(i1.ex_mr), .mem_rd_i(i1.mem_rd), .mem_reg_write_i(i1.mem_rw),
        .wb_rd_i(i1.wb_rd), .wb_reg_write_i(i1.wb_rw), .dmem_req_i(i1.req), .dmem_ready_i(i1.rdy),
        .retire_i(i1.retire), .pc_write_o(ctrl1[4]), .if_id_write_o(ctrl1[3]), .if_id_flush_o(ctrl1[2]),
        .id_ex_flush_o(ctrl1[1]), .pipe_hold_o(ctrl1[0]), .forward_a_o(fa1), .forward_b_o(fb1),
        .halted_o(h1), .cycle_cnt_o(cyc1), .stall_cnt_o(stl1), .retire_cnt_o(ret1)
    );

    function automatic exp_t ex(int t, logic d, logic [4:0] c, logic [1:0] a, logic [1:0] b,
                                logic k, logic h, int cy, int st, int rt);
        exp_t e;
        e.tag = t; e.d = d; e.ctrl = c; e.fa = a; e.fb = b; e.chk = k; e.halted = h;
        e.cyc = 32'(cy); e.stl = 32'(st); e.ret = 32'(rt);
        return e;
    endfunction

    task automatic step(input logic d, input in_t v, input exp_t e);
        @(posedge clk);
        #1;
        if (d) i1 = v; else i0 = v;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [4:0] c;
            logic [1:0] a, b;
            logic h;
            logic [31:0] cy, st, rt;
            logic bad;
            e  = q.pop_front();
            c  = e.d ? ctrl1 : ctrl0;
            a  = e.d ? fa1 : fa0;
            b  = e.d ? fb1 : fb0;
            h  = e.d ? h1 : h0;
            cy = e.d ? {28'b0, cyc1} : cyc0;
            st = e.d ? {28'b0, stl1} : stl0;
            rt = e.d ? {28'b0, ret1} : ret0;
            bad = c !== e.ctrl || a !== e.fa || b !== e.fb ||
                  (e.chk && (h !== e.halted || cy !== e.cyc || st !== e.stl || rt !== e.ret));
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL vec%0d u%0d: got ctrl=%b fa=%b fb=%b h=%b cyc=%0d stl=%0d ret=%0d, want ctrl=%b fa=%b fb=%b h=%b cyc=%0d stl=%0d ret=%0d (counters checked=%b)",
                         e.tag, e.d, c, a, b, h, cy, st, rt, e.ctrl, e.fa, e.fb, e.halted, e.cyc, e.stl, e.ret, e.chk);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        in_t v;
        i0 = '0; i0.reset = 1'b1;
        i1 = '0; i1.reset = 1'b1;
        // u0: reset, load-use, forwarding, dmem wait with jump, halt drain
        v = '0; v.reset = 1; step(0, v, ex(1, 0, C_RST, 0, 0, 0, 0, 0, 0, 0));
        v = '0; v.reset = 1; step(0, v, ex(2, 0, C_RST, 0, 0, 1, 0, 0, 0, 0));
        v = '0;              step(0, v, ex(3, 0, C_RUN, 0, 0, 1, 0, 0, 0, 0));
        v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 3; v.id_rs = 3; v.uses_rs = 1;
        step(0, v, ex(4, 0, C_BUB, 0, 0, 1, 0, 1, 0, 0));
        v = '0; v.retire = 1; step(0, v, ex(5, 0, C_RUN, 0, 0, 1, 0, 2, 1, 0));
        v = '0; v.mem_rd = 5; v.mem_rw = 1; v.wb_rd = 5; v.wb_rw = 1; v.ex_rs = 5;
        step(0, v, ex(6, 0, C_RUN, 2'b10, 2'b00, 1, 0, 3, 1, 1));
        v.mem_rw = 0;        step(0, v, ex(7, 0, C_RUN, 2'b01, 2'b00, 0, 0, 0, 0, 0));
        v.mem_rw = 1; v.ex_rs = 0; v.ex_rt = 5;
        step(0, v, ex(8, 0, C_RUN, 2'b00, 2'b10, 0, 0, 0, 0, 0));
        v = '0; v.mem_rw = 1; v.wb_rw = 1; v.ex_mr = 1; v.ex_rw = 1; v.uses_rs = 1;
        step(0, v, ex(9, 0, C_RUN, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        v = '0; v.req = 1; v.jump = 1;
        step(0, v, ex(10, 0, C_HOLD, 0, 0, 1, 0, 7, 1, 1));
        step(0, v, ex(11, 0, C_HOLD, 0, 0, 1, 0, 8, 2, 1));
        step(0, v, ex(12, 0, C_HOLD, 0, 0, 1, 0, 9, 3, 1));
        v.rdy = 1;           step(0, v, ex(13, 0, C_JMP, 0, 0, 1, 0, 10, 4, 1));
        v = '0; v.halt = 1;  step(0, v, ex(14, 0, C_BUB, 0, 0, 1, 0, 11, 4, 1));
        v = '0;              step(0, v, ex(15, 0, C_BUB, 0, 0, 1, 0, 12, 4, 1));
        v = '0; v.req = 1;   step(0, v, ex(16, 0, C_HOLD, 0, 0, 1, 0, 13, 4, 1));
        v = '0;              step(0, v, ex(17, 0, C_BUB, 0, 0, 1, 0, 14, 5, 1));
        step(0, v, ex(18, 0, C_BUB, 0, 0, 1, 0, 15, 5, 1));
        step(0, v, ex(19, 0, C_BUB, 0, 0, 1, 1, 16, 5, 1));
        v.retire = 1;        step(0, v, ex(20, 0, C_BUB, 0, 0, 1, 1, 16, 5, 1));
        v.retire = 0;        step(0, v, ex(21, 0, C_BUB, 0, 0, 1, 1, 16, 5, 2));
        v = '0; v.reset = 1; v.mem_rw = 1; v.mem_rd = 5; v.ex_rs = 5;
        step(0, v, ex(22, 0, C_RST, 0, 0, 0, 0, 0, 0, 0));
        v = '0;              step(0, v, ex(23, 0, C_RUN, 0, 0, 1, 0, 0, 0, 0));
        // u1: stall instead of forward, counter saturation, reset mid-drain
        v = '0; v.reset = 1; step(1, v, ex(101, 1, C_RST, 0, 0, 1, 0, 0, 0, 0));
        v = '0; v.wb_rd = 2; v.wb_rw = 1; v.id_rt = 2; v.uses_rt = 1; v.ex_rt = 2;
        step(1, v, ex(102, 1, C_BUB, 0, 0, 1, 0, 0, 0, 0));
        v = '0; v.mem_rd = 4; v.mem_rw = 1; v.ex_rs = 4; v.id_rs = 4; v.uses_rs = 1;
        step(1, v, ex(103, 1, C_BUB, 0, 0, 1, 0, 1, 1, 0));
        for (int n = 4; n <= 20; n++) begin
            v = '0;
            step(1, v, ex(100 + n, 1, C_RUN, 0, 0, 1, 0, (n - 2 > 15) ? 15 : n - 2, 2, 0));
        end
        v = '0; v.halt = 1;  step(1, v, ex(121, 1, C_BUB, 0, 0, 1, 0, 15, 2, 0));
        v = '0;              step(1, v, ex(122, 1, C_BUB, 0, 0, 1, 0, 15, 2, 0));
        v = '0; v.reset = 1; step(1, v, ex(123, 1, C_RST, 0, 0, 0, 0, 0, 0, 0));
        v = '0;              step(1, v, ex(124, 1, C_RUN, 0, 0, 1, 0, 0, 0, 0));
        v = '0; v.jump = 1;  step(1, v, ex(125, 1, C_JMP, 0, 0, 1, 0, 1, 0, 0));
        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
